// File: rtl/jtopl_pkg.sv
// Shared jtopl constants: attenuation/slot widths and the key-scale level ROM.
package jtopl_pkg;

  localparam int unsigned EgwDefault = 10;
  localparam int unsigned SlotW      = 6;
  localparam int unsigned KslW       = 9;
  localparam int unsigned AmW        = 6;

  function automatic logic [6:0] ksl_lut(input logic [3:0] fnum);
    logic [6:0] v;
    unique case (fnum)
      4'd0:  v = 7'd0;
      4'd1:  v = 7'd32;
      4'd2:  v = 7'd40;
      4'd3:  v = 7'd45;
      4'd4:  v = 7'd48;
      4'd5:  v = 7'd51;
      4'd6:  v = 7'd53;
      4'd7:  v = 7'd55;
      4'd8:  v = 7'd56;
      4'd9:  v = 7'd58;
      4'd10: v = 7'd59;
      4'd11: v = 7'd60;
      4'd12: v = 7'd61;
      4'd13: v = 7'd62;
      4'd14: v = 7'd63;
      default: v = 7'd64;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/jtopl_eg_ksl.sv
// Combinational key-scale level attenuation from F-number, octave and KSL depth.
module jtopl_eg_ksl
  import jtopl_pkg::*;
(
  input  logic [3:0]      fnum,
  input  logic [2:0]      block,
  input  logic [1:0]      ksl,
  output logic [KslW-1:0] ksl_db
);

  logic [3:0]      oct_gap;
  logic [7:0]      base;
  logic [KslW-1:0] scaled;

  always_comb begin
    oct_gap = 4'd8 - {1'b0, block};
    // base[7] is the sign of the 8-bit signed difference
    base    = {1'b0, ksl_lut(fnum)} - {1'b0, oct_gap[3:0], 3'b000};
    scaled  = {base[6:0], 2'b00};
    if (base[7] || (ksl == 2'd0)) begin
      ksl_db = '0;
    end else begin
      ksl_db = scaled >> (2'd3 - ksl);
    end
  end

endmodule

// File: rtl/jtopl_eg_final_pipe.sv
// Two-stage envelope output pipe: adds TL/KSL/AM to the raw envelope, saturates,
// tags each result with its slot and tracks per-frame saturation.
module jtopl_eg_final_pipe
  import jtopl_pkg::*;
#(
  parameter int unsigned EGW   = EgwDefault,
  parameter int unsigned SLOTS = 18
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cen,
  input  logic             in_valid,
  input  logic             zero,
  input  logic [3:0]       lfo_mod,
  input  logic [3:0]       fnum,
  input  logic [2:0]       block,
  input  logic             amsen,
  input  logic             ams,
  input  logic [5:0]       tl,
  input  logic [1:0]       ksl,
  input  logic [EGW-1:0]   eg_pure_in,
  output logic             out_valid,
  output logic [EGW-1:0]   eg_limited,
  output logic [SlotW-1:0] out_slot,
  output logic             out_sat,
  output logic             frame_sat
);

  localparam int unsigned SumW = EGW + 3;
  localparam logic [SlotW-1:0] LastSlot = SlotW'(SLOTS - 1);

  logic [KslW-1:0]  ksl_db;
  logic [AmW-1:0]   am;
  logic [SlotW-1:0] slot_in;

  logic             s1_valid_q, s1_valid_d;
  logic [KslW-1:0]  s1_ksl_q, s1_ksl_d;
  logic [AmW-1:0]   s1_am_q, s1_am_d;
  logic [5:0]       s1_tl_q, s1_tl_d;
  logic [EGW-1:0]   s1_eg_q, s1_eg_d;
  logic [SlotW-1:0] s1_slot_q, s1_slot_d;
  logic [SlotW-1:0] cnt_q, cnt_d;

  logic             out_valid_q, out_valid_d;
  logic [EGW-1:0]   eg_lim_q, eg_lim_d;
  logic [SlotW-1:0] out_slot_q, out_slot_d;
  logic             out_sat_q, out_sat_d;
  logic             frame_sat_q, frame_sat_d;
  logic             acc_q, acc_d;
  logic             nonempty_q, nonempty_d;

  logic [SumW-1:0]  atten, sum;
  logic             sat;

  jtopl_eg_ksl u_ksl (
    .fnum   (fnum),
    .block  (block),
    .ksl    (ksl),
    .ksl_db (ksl_db)
  );

  always_comb begin
    am      = !amsen ? '0 : (ams ? {lfo_mod, 2'b00} : {2'b00, lfo_mod});
    slot_in = zero ? '0 : cnt_q;

    atten = SumW'({s1_tl_q, 3'b000}) + SumW'({s1_ksl_q, 1'b0}) + SumW'(s1_am_q);
    sum   = (atten << (EGW - 10)) + SumW'(s1_eg_q);
    sat   = |sum[SumW-1:EGW];

    s1_valid_d  = s1_valid_q;
    s1_ksl_d    = s1_ksl_q;
    s1_am_d     = s1_am_q;
    s1_tl_d     = s1_tl_q;
    s1_eg_d     = s1_eg_q;
    s1_slot_d   = s1_slot_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    eg_lim_d    = eg_lim_q;
    out_slot_d  = out_slot_q;
    out_sat_d   = out_sat_q;
    frame_sat_d = frame_sat_q;
    acc_d       = acc_q;
    nonempty_d  = nonempty_q;

    if (cen) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_ksl_d  = ksl_db;
        s1_am_d   = am;
        s1_tl_d   = tl;
        s1_eg_d   = eg_pure_in;
        s1_slot_d = slot_in;
        cnt_d     = (slot_in == LastSlot) ? '0 : slot_in + 1'b1;
      end else if (zero) begin
        cnt_d = '0;
      end

      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        eg_lim_d   = sat ? '1 : sum[EGW-1:0];
        out_slot_d = s1_slot_q;
        out_sat_d  = sat;
        if (s1_slot_q == LastSlot) begin
          frame_sat_d = acc_q | sat;
          acc_d       = 1'b0;
          nonempty_d  = 1'b0;
        end else if ((s1_slot_q == '0) && nonempty_q) begin
          // a slot 0 closes the previous frame and opens the next one
          frame_sat_d = acc_q;
          acc_d       = sat;
          nonempty_d  = 1'b1;
        end else begin
          acc_d      = acc_q | sat;
          nonempty_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_ksl_q    <= '0;
      s1_am_q     <= '0;
      s1_tl_q     <= '0;
      s1_eg_q     <= '0;
      s1_slot_q   <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      eg_lim_q    <= '0;
      out_slot_q  <= '0;
      out_sat_q   <= 1'b0;
      frame_sat_q <= 1'b0;
      acc_q       <= 1'b0;
      nonempty_q  <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_ksl_q    <= s1_ksl_d;
      s1_am_q     <= s1_am_d;
      s1_tl_q     <= s1_tl_d;
      s1_eg_q     <= s1_eg_d;
      s1_slot_q   <= s1_slot_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      eg_lim_q    <= eg_lim_d;
      out_slot_q  <= out_slot_d;
      out_sat_q   <= out_sat_d;
      frame_sat_q <= frame_sat_d;
      acc_q       <= acc_d;
      nonempty_q  <= nonempty_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign eg_limited = eg_lim_q;
  assign out_slot   = out_slot_q;
  assign out_sat    = out_sat_q;
  assign frame_sat  = frame_sat_q;

endmodule

// File: tb/tb_jtopl_eg_final_pipe.sv
// Directed bench for jtopl_eg_final_pipe: vector table plus frame, reset and cen sequences.
module tb_jtopl_eg_final_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cen = 1'b1;
  logic        in_valid = 1'b0;
  logic        zero = 1'b0;
  logic [3:0]  lfo_mod = '0;
  logic [3:0]  fnum = '0;
  logic [2:0]  block = '0;
  logic        amsen = 1'b0;
  logic        ams = 1'b0;
  logic [5:0]  tl = '0;
  logic [1:0]  ksl = '0;
  logic [9:0]  eg10 = '0;
  logic [11:0] eg12 = '0;

  logic        ov10, sat10, fs10, ov12, sat12, fs12;
  logic [9:0]  lim10;
  logic [11:0] lim12;
  logic [5:0]  slot10, slot12;

  int n_vec = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  jtopl_eg_final_pipe #(.EGW(10), .SLOTS(18)) dut (
    .clk(clk), .rst(rst), .cen(cen), .in_valid(in_valid), .zero(zero), .lfo_mod(lfo_mod),
    .fnum(fnum), .block(block), .amsen(amsen), .ams(ams), .tl(tl), .ksl(ksl),
    .eg_pure_in(eg10), .out_valid(ov10), .eg_limited(lim10), .out_slot(slot10),
    .out_sat(sat10), .frame_sat(fs10)
  );

  jtopl_eg_final_pipe #(.EGW(12), .SLOTS(18)) dut12 (
    .clk(clk), .rst(rst), .cen(cen), .in_valid(in_valid), .zero(zero), .lfo_mod(lfo_mod),
    .fnum(fnum), .block(block), .amsen(amsen), .ams(ams), .tl(tl), .ksl(ksl),
    .eg_pure_in(eg12), .out_valid(ov12), .eg_limited(lim12), .out_slot(slot12),
    .out_sat(sat12), .frame_sat(fs12)
  );

  typedef struct {
    logic [3:0]  fnum;
    logic [2:0]  block;
    logic [1:0]  ksl;
    logic [5:0]  tl;
    logic        amsen;
    logic        ams;
    logic [3:0]  lfo;
    logic [11:0] eg;
    logic        use12;
    logic [12:0] exp_val;
    logic        exp_sat;
  } vec_t;

  vec_t vecs[14];

  // stream monitor state
  logic mon_on = 1'b0;
  logic prev_valid = 1'b0;
  int   exp_slot = 0;
  int   n_out = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (mon_on) begin
      if (cen) begin
        if (ov10) begin
          chk("stream_slot", 32'(slot10), 32'(exp_slot));
          exp_slot++;
          n_out++;
        end
      end else begin
        chk("stream_hold", 32'(ov10), 32'(prev_valid));
      end
      prev_valid = ov10;
    end
  endtask

  task automatic feed(input logic v, input logic z, input logic [5:0] t, input logic [9:0] e);
    in_valid = v;
    zero     = z;
    tl       = t;
    eg10     = e;
    eg12     = {2'b00, e};
    fnum     = '0;
    block    = '0;
    ksl      = '0;
    amsen    = 1'b0;
    ams      = 1'b0;
    lfo_mod  = '0;
    cen      = 1'b1;
    tick();
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    zero     = 1'b0;
    cen      = 1'b1;
    rst      = 1'b1;
    tick();
    tick();
    rst      = 1'b0;
  endtask

  initial begin
    //        fnum block ksl tl  amsen ams lfo eg      use12 exp   sat
    vecs[0]  = '{4'd15, 3'd7, 2'd3, 6'd0,  1'b0, 1'b0, 4'd0,  12'd0,    1'b0, 13'd448,  1'b0};
    vecs[1]  = '{4'd15, 3'd7, 2'd1, 6'd0,  1'b0, 1'b0, 4'd0,  12'd0,    1'b0, 13'd112,  1'b0};
    vecs[2]  = '{4'd15, 3'd0, 2'd3, 6'd0,  1'b0, 1'b0, 4'd0,  12'd0,    1'b0, 13'd0,    1'b0};
    vecs[3]  = '{4'd8,  3'd0, 2'd3, 6'd0,  1'b0, 1'b0, 4'd0,  12'd0,    1'b0, 13'd0,    1'b0};
    vecs[4]  = '{4'd0,  3'd0, 2'd0, 6'd63, 1'b0, 1'b0, 4'd0,  12'h3FF,  1'b0, 13'd1023, 1'b1};
    vecs[5]  = '{4'd0,  3'd0, 2'd0, 6'd0,  1'b1, 1'b1, 4'd15, 12'd100,  1'b0, 13'd160,  1'b0};
    vecs[6]  = '{4'd0,  3'd0, 2'd0, 6'd0,  1'b1, 1'b0, 4'd15, 12'd100,  1'b0, 13'd115,  1'b0};
    vecs[7]  = '{4'd0,  3'd0, 2'd0, 6'd1,  1'b0, 1'b0, 4'd0,  12'd5,    1'b1, 13'd37,   1'b0};
    vecs[8]  = '{4'd4,  3'd5, 2'd2, 6'd2,  1'b0, 1'b0, 4'd0,  12'd10,   1'b0, 13'd122,  1'b0};
    vecs[9]  = '{4'd15, 3'd7, 2'd3, 6'd40, 1'b0, 1'b0, 4'd0,  12'd600,  1'b0, 13'd1023, 1'b1};
    vecs[10] = '{4'd15, 3'd7, 2'd0, 6'd0,  1'b0, 1'b0, 4'd0,  12'd7,    1'b0, 13'd7,    1'b0};
    vecs[11] = '{4'd0,  3'd0, 2'd0, 6'd0,  1'b0, 1'b0, 4'd0,  12'd1023, 1'b0, 13'd1023, 1'b0};
    vecs[12] = '{4'd0,  3'd0, 2'd0, 6'd1,  1'b0, 1'b0, 4'd0,  12'd1016, 1'b0, 13'd1023, 1'b1};
    vecs[13] = '{4'd0,  3'd0, 2'd0, 6'd63, 1'b0, 1'b0, 4'd0,  12'hFFF,  1'b1, 13'd4095, 1'b1};

    do_reset();
    chk("rst_valid", 32'(ov10), 32'd0);
    chk("rst_eg", 32'(lim10), 32'd0);
    chk("rst_slot", 32'(slot10), 32'd0);
    chk("rst_sat", 32'(sat10), 32'd0);
    chk("rst_fsat", 32'(fs10), 32'd0);

    for (int i = 0; i < 14; i++) begin
      fnum     = vecs[i].fnum;
      block    = vecs[i].block;
      ksl      = vecs[i].ksl;
      tl       = vecs[i].tl;
      amsen    = vecs[i].amsen;
      ams      = vecs[i].ams;
      lfo_mod  = vecs[i].lfo;
      eg10     = vecs[i].eg[9:0];
      eg12     = vecs[i].eg;
      in_valid = 1'b1;
      zero     = 1'b1;
      cen      = 1'b1;
      tick();
      chk($sformatf("vec%0d_lat1", i), 32'(ov10), 32'd0);
      in_valid = 1'b0;
      zero     = 1'b0;
      tick();
      if (vecs[i].use12) begin
        chk($sformatf("vec%0d_valid12", i), 32'(ov12), 32'd1);
        chk($sformatf("vec%0d_eg12", i), 32'(lim12), 32'(vecs[i].exp_val));
        chk($sformatf("vec%0d_sat12", i), 32'(sat12), 32'(vecs[i].exp_sat));
      end else begin
        chk($sformatf("vec%0d_valid", i), 32'(ov10), 32'd1);
        chk($sformatf("vec%0d_eg", i), 32'(lim10), 32'(vecs[i].exp_val));
        chk($sformatf("vec%0d_sat", i), 32'(sat10), 32'(vecs[i].exp_sat));
      end
    end

    // Frame with one saturating slot (3): frame_sat rises with the slot 17 output
    do_reset();
    for (int s = 0; s < 18; s++) begin
      feed(1'b1, s == 0, (s == 3) ? 6'd63 : 6'd0, (s == 3) ? 10'h3FF : 10'(s));
    end
    chk("f1_pre_fsat", 32'(fs10), 32'd0);
    feed(1'b0, 1'b0, 6'd0, 10'd0);
    chk("f1_slot17", 32'(slot10), 32'd17);
    chk("f1_fsat", 32'(fs10), 32'd1);

    // Partial next frame, then asynchronous reset between clock edges
    for (int s = 0; s < 10; s++) begin
      feed(1'b1, 1'b0, 6'd10, 10'(50 + s));
    end
    chk("pre_rst_slot", 32'(slot10), 32'd8);
    chk("pre_rst_eg", 32'(lim10), 32'd138);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", 32'(ov10), 32'd0);
    chk("arst_eg", 32'(lim10), 32'd0);
    chk("arst_slot", 32'(slot10), 32'd0);
    chk("arst_sat", 32'(sat10), 32'd0);
    chk("arst_fsat", 32'(fs10), 32'd0);
    tick();
    rst = 1'b0;
    feed(1'b1, 1'b0, 6'd0, 10'd77);
    feed(1'b0, 1'b0, 6'd0, 10'd0);
    chk("post_rst_valid", 32'(ov10), 32'd1);
    chk("post_rst_slot", 32'(slot10), 32'd0);
    chk("post_rst_eg", 32'(lim10), 32'd77);

    // Saturation on the ending slot itself is included, then a clean frame clears it
    for (int s = 0; s < 18; s++) begin
      feed(1'b1, s == 0, (s == 17) ? 6'd63 : 6'd0, (s == 17) ? 10'h3FF : 10'd1);
    end
    feed(1'b0, 1'b0, 6'd0, 10'd0);
    chk("f2_sat17", 32'(sat10), 32'd1);
    chk("f2_fsat", 32'(fs10), 32'd1);
    for (int s = 0; s < 18; s++) begin
      feed(1'b1, s == 0, 6'd0, 10'd2);
    end
    feed(1'b0, 1'b0, 6'd0, 10'd0);
    chk("f3_slot17", 32'(slot10), 32'd17);
    chk("f3_fsat", 32'(fs10), 32'd0);

    // Short frame closed by a zero-only cycle; the following slot 0 ends it
    feed(1'b1, 1'b1, 6'd0, 10'd3);
    feed(1'b1, 1'b0, 6'd63, 10'h3FF);
    feed(1'b1, 1'b0, 6'd0, 10'd4);
    feed(1'b0, 1'b1, 6'd0, 10'd0);
    chk("z_slot2", 32'(slot10), 32'd2);
    chk("z_fsat_pre", 32'(fs10), 32'd0);
    feed(1'b1, 1'b0, 6'd0, 10'd9);
    chk("z_no_out", 32'(ov10), 32'd0);
    feed(1'b0, 1'b0, 6'd0, 10'd0);
    chk("z_slot0", 32'(slot10), 32'd0);
    chk("z_eg", 32'(lim10), 32'd9);
    chk("z_fsat", 32'(fs10), 32'd1);

    // cen 1-of-4 stream of 18 slots with a bubble in the sixth cen cycle
    do_reset();
    exp_slot   = 0;
    n_out      = 0;
    prev_valid = ov10;
    mon_on     = 1'b1;
    for (int i = 0; i < 22; i++) begin
      in_valid = (i < 19) && (i != 5);
      zero     = (i == 0);
      tl       = 6'd0;
      eg10     = 10'(i);
      eg12     = 12'(i);
      cen      = 1'b1;
      tick();
      cen = 1'b0;
      repeat (3) tick();
    end
    mon_on = 1'b0;
    chk("stream_count", 32'(n_out), 32'd18);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
